// File: rtl/sram_responder.sv
// Word-wide single-port SRAM responder with req/ready handshake and a programmable
// read latency; read data returns with a one-cycle rdata_valid strobe.
module sram_responder #(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic [1:0]  fsm_state
);

    // Handshake: a request transfers on a rising edge where req & ready are both 1.
    // ready is combinational (low in WAIT and while reset is high); we, addr and
    // wdata are only sampled on that transfer edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t            state;
    state_t            state_n;
    logic [2:0]        cnt;
    logic [2:0]        cnt_n;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              misaligned;
    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic [31:0]       cap_data;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic              going_resp;
    logic              unused_addr;

    // Upper address bits alias onto the same words.
    assign idx         = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign misaligned  = |addr[1:0];

    assign ready     = (state != WAIT) & ~reset;
    assign accept    = req & ready;
    assign rd_accept = accept & ~we;
    assign wr_accept = accept & we;
    assign fsm_state = state;

    // Read-first capture; a misaligned read returns zero data.
    assign cap_data = misaligned ? 32'd0 : mem[idx];

    // LATENCY=1 enters RESP straight from an accept; longer latencies come from WAIT.
    assign resp_data  = (state == WAIT) ? rdata_q : cap_data;
    assign resp_err   = (state == WAIT) ? err_q : misaligned;
    assign going_resp = (state_n == RESP);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, RESP: begin
                state_n = IDLE;
                if (rd_accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rdata_valid <= going_resp;
            rdata       <= going_resp ? resp_data : 32'd0;
            err         <= (wr_accept & misaligned) | (going_resp & resp_err);
            if (rd_accept) begin
                rdata_q <= cap_data;
                err_q   <= misaligned;
            end
        end
    end

    // Storage is deliberately left out of reset; misaligned writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_accept && !misaligned) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (LATENCY 1, 3, 4) driven one at a time,
// checked every cycle against a transaction-level model with a due-cycle queue.
module tb_sram_responder;

  logic        clk;
  logic        rst    [3];
  logic        req    [3];
  logic        we     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        rdy    [3];
  logic [31:0] rdata  [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [1:0]  fsm    [3];

  int lat [3] = '{1, 3, 4};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(10), .LATENCY(1), .INIT_FILE("")) u_l1 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(rdy[0]), .rdata(rdata[0]), .rdata_valid(rvalid[0]),
    .err(err[0]), .fsm_state(fsm[0]));

  sram_responder #(.ADDR_W(10), .LATENCY(3), .INIT_FILE("")) u_l3 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(rdy[1]), .rdata(rdata[1]), .rdata_valid(rvalid[1]),
    .err(err[1]), .fsm_state(fsm[1]));

  sram_responder #(.ADDR_W(10), .LATENCY(4), .INIT_FILE("")) u_l4 (
    .clk(clk), .reset(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ready(rdy[2]), .rdata(rdata[2]), .rdata_valid(rvalid[2]),
    .err(err[2]), .fsm_state(fsm[2]));

  // ---------------- reference model ----------------
  int          total = 0;
  int          bad   = 0;
  int          cur   = 0;
  int          cyc   = 0;
  int          busy_left = 0;
  int          werr_due  = -1;
  int          due_q [$];
  logic [31:0] exp_q [$];
  bit          eerr_q [$];
  logic [31:0] mdl [3][1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, cur, cyc, obs, expv);
    end
  endtask

  // One clock cycle on instance cur: drive, check this cycle, advance the model.
  task automatic step(input bit rv, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d);
    bit          e_ready;
    bit          e_valid;
    bit          e_err;
    logic [31:0] e_rdata;
    int          k;
    int          wi;
    k = cur;
    rst[k] = rv; req[k] = r; we[k] = w; addr[k] = a; wdata[k] = d;
    #1;
    e_ready = !rv && (busy_left == 0);
    e_valid = (due_q.size() > 0) && (due_q[0] == cyc);
    e_rdata = e_valid ? exp_q[0] : 32'd0;
    e_err   = (e_valid && eerr_q[0]) || (werr_due == cyc);
    chk("ready", {31'd0, rdy[k]}, {31'd0, e_ready});
    chk("rdata_valid", {31'd0, rvalid[k]}, {31'd0, e_valid});
    chk("rdata", rdata[k], e_rdata);
    chk("err", {31'd0, err[k]}, {31'd0, e_err});
    if (e_valid) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      void'(eerr_q.pop_front());
    end
    if (rv) begin
      due_q.delete();
      exp_q.delete();
      eerr_q.delete();
      busy_left = 0;
      werr_due  = -1;
    end else begin
      if (busy_left > 0) busy_left--;
      if (r && e_ready) begin
        wi = int'(a[11:2]);
        if (w) begin
          if (a[1:0] == 2'b00) mdl[k][wi] = d;
          else werr_due = cyc + 1;
        end else begin
          due_q.push_back(cyc + lat[k]);
          exp_q.push_back((a[1:0] == 2'b00) ? mdl[k][wi] : 32'd0);
          eerr_q.push_back(a[1:0] != 2'b00);
          busy_left = lat[k] - 1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (due_q.size() > 0 || busy_left > 0 || werr_due >= cyc); i++)
      idle();
    chk("drain_done", {31'd0, (due_q.size() > 0 || busy_left > 0)}, 32'd0);
  endtask

  task automatic random_traffic(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom);
    end
    drain();
  endtask

  task automatic fill_words();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 32'(i * 4), $urandom);
    drain();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // LATENCY=1 instance
    cur = 0;
    step(1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);   // reset state, req ignored
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    fill_words();
    step(1'b0, 1'b1, 1'b1, 32'h1c00_0000, 32'h1234_5678);
    step(1'b0, 1'b1, 1'b0, 32'h1c00_0000, 32'h0);
    idle();
    drain();
    chk("l1_basic_model", mdl[0][0], 32'h1234_5678);
    // write into the RESP cycle of the same address
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'h5A5A_5A5A);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drain();
    // misaligned read and write
    step(1'b0, 1'b1, 1'b0, 32'h1c00_0002, 32'h0);
    idle();
    step(1'b0, 1'b1, 1'b1, 32'h3, 32'hFFFF_FFFF);
    idle();
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drain();
    // aliasing
    step(1'b0, 1'b1, 1'b1, 32'h4, 32'hCAFE_F00D);
    step(1'b0, 1'b1, 1'b0, 32'h1004, 32'h0);
    drain();
    // back-to-back reads
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    drain();
    random_traffic(120);

    // LATENCY=3 instance
    cur = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    fill_words();
    step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);             // accept, cycle 0
    step(1'b0, 1'b1, 1'b1, 32'h20, 32'h0BAD_0BAD);   // ready=0, not accepted
    idle();
    idle();                                           // rdata_valid here
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);            // old value at 0x20
    drain();
    random_traffic(120);

    // LATENCY=4 instance: reset mid-read
    cur = 2;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    fill_words();
    step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    idle();
    step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    idle();
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 32'hC, 32'h0);
    drain();
    random_traffic(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
